// File: rtl/exc_commit_unit.sv
// WB-stage exception/interrupt committer: prioritises exceptions, issues one-cycle CSR pulses and
// holds flush until the CSR redirect (exlike) is seen. Optional EXC_STAT_CNT_EN adds exc/int counters.
module exc_commit_unit #(
    parameter int FLUSH_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic [14:0] wb_exc,
    input  logic        wb_priv,
    input  logic        wb_ertn,
    input  logic        wb_refetch,
    input  logic [1:0]  plv,
    input  logic        ie,
    input  logic [11:0] lie,
    input  logic [11:0] is,
    input  logic        exlike,
    output logic        wb_commit,
    output logic        is_exc,
    output logic        is_ertn,
    output logic        is_fetch_again,
    output logic [5:0]  excode,
    output logic [8:0]  esubcode,
    output logic [31:0] badvaddr,
    output logic [31:0] csr_pc,
    output logic        flush
`ifdef EXC_STAT_CNT_EN
    ,
    output logic [31:0] exc_cnt,
    output logic [31:0] int_cnt
`endif
);

    localparam int CW = $clog2(FLUSH_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_LAT);

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef enum logic {S_IDLE, S_FLUSH} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic          int_q, int_d;
    logic          wb_ready_q, wb_ready_d;
    logic          flush_q, flush_d;
    logic          wb_commit_q, wb_commit_d;
    logic          is_exc_q, is_exc_d;
    logic          is_ertn_q, is_ertn_d;
    logic          is_fa_q, is_fa_d;
    logic [5:0]    excode_q, excode_d;
    logic [8:0]    esubcode_q, esubcode_d;
    logic [31:0]   badvaddr_q, badvaddr_d;
    logic [31:0]   csr_pc_q, csr_pc_d;

    logic          ipe;
    logic          exc_any;
    logic          pulse;
    logic [5:0]    exc_code;
    logic [8:0]    exc_sub;
    logic [31:0]   exc_bva;
    logic          unused_rsvd;

    assign unused_rsvd = wb_exc[14];

    // Highest-priority cause wins; fetch-side faults report the PC, memory-side faults the vaddr.
    always_comb begin
        ipe      = wb_priv & (plv != 2'd0);
        exc_any  = 1'b1;
        exc_code = '0;
        exc_sub  = '0;
        exc_bva  = '0;
        if (int_q)            exc_code = ECODE_INT;
        else if (wb_exc[0])  begin exc_code = ECODE_ADE;  exc_bva = wb_pc;    end
        else if (wb_exc[1])  begin exc_code = ECODE_TLBR; exc_bva = wb_pc;    end
        else if (wb_exc[2])  begin exc_code = ECODE_PIF;  exc_bva = wb_pc;    end
        else if (wb_exc[3])  begin exc_code = ECODE_PPI;  exc_bva = wb_pc;    end
        else if (wb_exc[4])   exc_code = ECODE_INE;
        else if (ipe)         exc_code = ECODE_IPE;
        else if (wb_exc[5])   exc_code = ECODE_SYS;
        else if (wb_exc[6])   exc_code = ECODE_BRK;
        else if (wb_exc[7])  begin exc_code = ECODE_ADE;  exc_sub = 9'd1; exc_bva = wb_vaddr; end
        else if (wb_exc[8])  begin exc_code = ECODE_ALE;  exc_bva = wb_vaddr; end
        else if (wb_exc[9])  begin exc_code = ECODE_TLBR; exc_bva = wb_vaddr; end
        else if (wb_exc[10]) begin exc_code = ECODE_PIL;  exc_bva = wb_vaddr; end
        else if (wb_exc[11]) begin exc_code = ECODE_PIS;  exc_bva = wb_vaddr; end
        else if (wb_exc[12]) begin exc_code = ECODE_PME;  exc_bva = wb_vaddr; end
        else if (wb_exc[13]) begin exc_code = ECODE_PPI;  exc_bva = wb_vaddr; end
        else                  exc_any  = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        int_d       = ie & (|(lie & is));
        wb_ready_d  = wb_ready_q;
        flush_d     = flush_q;
        wb_commit_d = 1'b0;
        is_exc_d    = 1'b0;
        is_ertn_d   = 1'b0;
        is_fa_d     = 1'b0;
        excode_d    = '0;
        esubcode_d  = '0;
        badvaddr_d  = '0;
        csr_pc_d    = csr_pc_q;
        pulse       = 1'b0;
        case (state_q)
            S_IDLE: begin
                flush_d    = 1'b0;
                wb_ready_d = 1'b1;
                if (wb_valid && wb_ready_q) begin
                    csr_pc_d = wb_pc;
                    if (exc_any) begin
                        is_exc_d   = 1'b1;
                        excode_d   = exc_code;
                        esubcode_d = exc_sub;
                        badvaddr_d = exc_bva;
                        pulse      = 1'b1;
                    end else if (wb_ertn) begin
                        is_ertn_d = 1'b1;
                        pulse     = 1'b1;
                    end else if (wb_refetch) begin
                        is_fa_d     = 1'b1;
                        wb_commit_d = 1'b1;
                        pulse       = 1'b1;
                    end else begin
                        wb_commit_d = 1'b1;
                    end
                    if (pulse) begin
                        flush_d    = 1'b1;
                        wb_ready_d = 1'b0;
                        cnt_d      = CNT_INIT;
                        seen_d     = 1'b0;
                        state_d    = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                flush_d    = 1'b1;
                wb_ready_d = 1'b0;
                seen_d     = seen_q | exlike;
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                // The redirect may land before the minimum flush window ends; it is remembered in seen_q.
                if ((cnt_q == '0) && (seen_q || exlike)) begin
                    state_d    = S_IDLE;
                    flush_d    = 1'b0;
                    wb_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                flush_d    = 1'b0;
                wb_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            int_q       <= 1'b0;
            wb_ready_q  <= 1'b1;
            flush_q     <= 1'b0;
            wb_commit_q <= 1'b0;
            is_exc_q    <= 1'b0;
            is_ertn_q   <= 1'b0;
            is_fa_q     <= 1'b0;
            excode_q    <= '0;
            esubcode_q  <= '0;
            badvaddr_q  <= '0;
            csr_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            int_q       <= int_d;
            wb_ready_q  <= wb_ready_d;
            flush_q     <= flush_d;
            wb_commit_q <= wb_commit_d;
            is_exc_q    <= is_exc_d;
            is_ertn_q   <= is_ertn_d;
            is_fa_q     <= is_fa_d;
            excode_q    <= excode_d;
            esubcode_q  <= esubcode_d;
            badvaddr_q  <= badvaddr_d;
            csr_pc_q    <= csr_pc_d;
        end
    end

    assign wb_ready       = wb_ready_q;
    assign flush          = flush_q;
    assign wb_commit      = wb_commit_q;
    assign is_exc         = is_exc_q;
    assign is_ertn        = is_ertn_q;
    assign is_fetch_again = is_fa_q;
    assign excode         = excode_q;
    assign esubcode       = esubcode_q;
    assign badvaddr       = badvaddr_q;
    assign csr_pc         = csr_pc_q;

`ifdef EXC_STAT_CNT_EN
    logic [31:0] exc_cnt_q, exc_cnt_d;
    logic [31:0] int_cnt_q, int_cnt_d;

    // Counted while the pulse is visible, so totals lag the pulse by one cycle.
    always_comb begin
        exc_cnt_d = exc_cnt_q;
        int_cnt_d = int_cnt_q;
        if (is_exc_q) begin
            exc_cnt_d = exc_cnt_q + 32'd1;
            if (excode_q == ECODE_INT) int_cnt_d = int_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cnt_q <= '0;
            int_cnt_q <= '0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
            int_cnt_q <= int_cnt_d;
        end
    end

    assign exc_cnt = exc_cnt_q;
    assign int_cnt = int_cnt_q;
`endif

endmodule

// File: tb/tb_exc_commit_unit.sv
// Randomized scoreboard bench for exc_commit_unit: a table-driven priority model predicts each
// commit/pulse, a negedge monitor pops and compares whatever the DUT presents.
module tb_exc_commit_unit;
    localparam int FLUSH_LAT = 2;

    typedef struct packed {
        logic        commit;
        logic        exc;
        logic        ertn;
        logic        fa;
        logic [5:0]  code;
        logic [8:0]  sub;
        logic [31:0] badv;
        logic [31:0] pc;
    } exp_t;

    // Priority order: INT, exc[0..4], IPE, exc[5..13]
    localparam logic [5:0] CODES [16] = '{6'h00, 6'h08, 6'h3F, 6'h03, 6'h07, 6'h0D, 6'h0E, 6'h0B,
                                          6'h0C, 6'h08, 6'h09, 6'h3F, 6'h01, 6'h02, 6'h04, 6'h07};

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_ready, wb_priv, wb_ertn, wb_refetch, ie, exlike;
    logic [31:0] wb_pc, wb_vaddr, badvaddr, csr_pc;
    logic [14:0] wb_exc;
    logic [1:0]  plv;
    logic [11:0] lie, is;
    logic        wb_commit, is_exc, is_ertn, is_fetch_again, flush;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] exc_cnt, int_cnt;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   exc_n = 0, int_n = 0;
    logic int_now = 1'b0, int_next = 1'b0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    exc_commit_unit #(.FLUSH_LAT(FLUSH_LAT)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .wb_exc(wb_exc), .wb_priv(wb_priv), .wb_ertn(wb_ertn),
        .wb_refetch(wb_refetch), .plv(plv), .ie(ie), .lie(lie), .is(is), .exlike(exlike),
        .wb_commit(wb_commit), .is_exc(is_exc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again),
        .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr), .csr_pc(csr_pc), .flush(flush)
`ifdef EXC_STAT_CNT_EN
        , .exc_cnt(exc_cnt), .int_cnt(int_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic intp, input logic [14:0] exc, input logic priv,
                                   input logic ertn, input logic refetch, input logic [1:0] pl,
                                   input logic [31:0] pc, input logic [31:0] va);
        exp_t        e;
        logic [15:0] hit;
        int          w;
        e   = '0;
        hit = {exc[13:5], priv && (pl != 2'd0), exc[4:0], intp};
        w   = -1;
        for (int i = 15; i >= 0; i--) if (hit[i]) w = i;
        e.pc = pc;
        if (w >= 0) begin
            e.exc  = 1'b1;
            e.code = CODES[w];
            e.sub  = (w == 9) ? 9'd1 : 9'd0;
            if (w >= 1 && w <= 4) e.badv = pc;
            else if (w >= 9)      e.badv = va;
        end else if (ertn) e.ertn = 1'b1;
        else if (refetch)  e.fa = 1'b1;
        e.commit = !e.exc && !e.ertn;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        int_now = int_next;
    endtask

    task automatic set_int(input logic ie_i, input logic [11:0] lie_i, input logic [11:0] is_i);
        ie = ie_i; lie = lie_i; is = is_i;
        int_next = ie_i & (|(lie_i & is_i));
    endtask

    task automatic rand_int();
        set_int(1'($urandom_range(0, 1)), 12'($urandom),
                ($urandom_range(0, 5) == 0) ? 12'($urandom) : 12'h0);
    endtask

    // Drives one instruction into an idle DUT; if it pulses, walks the flush window with junk
    // WB traffic and raises exlike d cycles after the pulse.
    task automatic instr(input logic [31:0] pc, input logic [31:0] va, input logic [14:0] exc,
                         input logic priv, input logic ertn, input logic refetch,
                         input logic [1:0] pl, input int d);
        exp_t e;
        int   len;
        wb_valid = 1'b1; wb_pc = pc; wb_vaddr = va; wb_exc = exc; wb_priv = priv;
        wb_ertn = ertn; wb_refetch = refetch; plv = pl;
        e = model(int_now, exc, priv, ertn, refetch, pl, pc, va);
        q.push_back(e);
        chk("ready_idle", 64'(wb_ready), 64'd1);
        if (e.exc) begin
            exc_n++;
            if (e.code == 6'h00) int_n++;
        end
        step();
        wb_valid = 1'b0;
        if (e.exc || e.ertn || e.fa) begin
            len = ((d > FLUSH_LAT) ? d : FLUSH_LAT) + 1;
            for (int j = 0; j < len; j++) begin
                chk("flush_held", 64'(flush), 64'd1);
                chk("ready_low", 64'(wb_ready), 64'd0);
                wb_valid = 1'($urandom_range(0, 1));
                wb_exc   = 15'($urandom_range(0, 1) << $urandom_range(0, 13));
                wb_ertn  = 1'($urandom_range(0, 1));
                exlike   = (j == d);
                step();
            end
            exlike = 1'b0; wb_valid = 1'b0;
            chk("flush_release", 64'(flush), 64'd0);
            chk("ready_release", 64'(wb_ready), 64'd1);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (!is_exc) chk("zero_when_no_exc", 64'({excode, esubcode, badvaddr}), 64'd0);
            if (wb_commit || is_exc || is_ertn || is_fetch_again) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output commit=%0b exc=%0b ertn=%0b fa=%0b expected none",
                             wb_commit, is_exc, is_ertn, is_fetch_again);
                end else begin
                    e = q.pop_front();
                    chk("commit", 64'(wb_commit), 64'(e.commit));
                    chk("is_exc", 64'(is_exc), 64'(e.exc));
                    chk("is_ertn", 64'(is_ertn), 64'(e.ertn));
                    chk("is_fetch_again", 64'(is_fetch_again), 64'(e.fa));
                    chk("excode", 64'(excode), 64'(e.code));
                    chk("esubcode", 64'(esubcode), 64'(e.sub));
                    chk("badvaddr", 64'(badvaddr), 64'(e.badv));
                    if (e.exc || e.ertn || e.fa) chk("csr_pc", 64'(csr_pc), 64'(e.pc));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_vaddr = '0; wb_exc = '0; wb_priv = 1'b0;
        wb_ertn = 1'b0; wb_refetch = 1'b0; plv = '0; exlike = 1'b0;
        set_int(1'b0, 12'h0, 12'h0);
        step();
        chk("rst_ready", 64'(wb_ready), 64'd1);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_pulses", 64'({wb_commit, is_exc, is_ertn, is_fetch_again}), 64'd0);
        chk("rst_fields", 64'({excode, esubcode, badvaddr}), 64'd0);
        chk("rst_csr_pc", 64'(csr_pc), 64'd0);
        step();
        reset = 1'b0; started = 1'b1;
        step();
        int_now = 1'b0;

        instr(32'h1c000000, 32'h0, 15'h0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        instr(32'h1c000004, 32'h0, 15'h0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        instr(32'h1c000100, 32'h0, 15'h0020, 1'b0, 1'b0, 1'b0, 2'd0, 1);
        instr(32'h1c000200, 32'h3, 15'h0500, 1'b0, 1'b0, 1'b0, 2'd0, 0);
        set_int(1'b1, 12'h800, 12'h800);
        step();
        instr(32'h1c000300, 32'h0, 15'h0040, 1'b0, 1'b0, 1'b0, 2'd0, 1);
        set_int(1'b0, 12'h0, 12'h0);
        step();
        instr(32'h1c000400, 32'h0, 15'h0, 1'b1, 1'b0, 1'b0, 2'd3, 1);
        instr(32'h1c000500, 32'h0, 15'h0, 1'b1, 1'b0, 1'b1, 2'd0, 2);
        instr(32'h1c000600, 32'h0, 15'h0020, 1'b0, 1'b0, 1'b0, 2'd0, 5);
        instr(32'h1c000700, 32'h0, 15'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
        instr(32'h1c000800, 32'h2000, 15'h0080, 1'b0, 1'b1, 1'b1, 2'd0, 3);
        set_int(1'b1, 12'h001, 12'h001);
        step();
        instr(32'h1c000900, 32'h0, 15'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
        set_int(1'b0, 12'h0, 12'h0);
        step();

        // Reset during FLUSH: the pulse already issued is still observed, then IDLE.
        instr_reset_in_flush();

        for (int n = 0; n < 300; n++) begin
            logic [14:0] ex;
            if ($urandom_range(0, 1) == 0) begin
                rand_int();
                wb_valid = 1'b0;
                step();
            end
            rand_int();
            ex = '0;
            if ($urandom_range(0, 2) == 0) ex[$urandom_range(0, 13)] = 1'b1;
            if ($urandom_range(0, 3) == 0) ex[$urandom_range(0, 13)] = 1'b1;
            instr($urandom, $urandom, ex, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)), $urandom_range(0, 6));
        end

        wb_valid = 1'b0;
        repeat (3) step();
        chk("queue_drained", 64'(q.size()), 64'd0);
`ifdef EXC_STAT_CNT_EN
        chk("exc_cnt", 64'(exc_cnt), 64'(exc_n));
        chk("int_cnt", 64'(int_cnt), 64'(int_n));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic instr_reset_in_flush();
        exp_t e;
        wb_valid = 1'b1; wb_pc = 32'h1c000a00; wb_vaddr = '0; wb_exc = 15'h0020;
        wb_priv = 1'b0; wb_ertn = 1'b0; wb_refetch = 1'b0; plv = '0;
        e = model(int_now, wb_exc, 1'b0, 1'b0, 1'b0, 2'd0, wb_pc, 32'h0);
        q.push_back(e);
        step();
        wb_valid = 1'b0;
        chk("pre_reset_flush", 64'(flush), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        int_now = 1'b0;
        exc_n = 0; int_n = 0;
        chk("mid_flush_rst_ready", 64'(wb_ready), 64'd1);
        chk("mid_flush_rst_flush", 64'(flush), 64'd0);
        chk("mid_flush_rst_pulse", 64'({is_exc, is_ertn, is_fetch_again, wb_commit}), 64'd0);
    endtask

endmodule
